// File: rtl/ddr_burst_sequencer.sv
// Burst initiator to the per-bank chip interface: one request in, BL registered beats out; read beats come
// back RDLAT+2 cycles after issue. Writes stall on wdata_valid; reads never stall and rdata has no backpressure.
module ddr_burst_sequencer #(
   parameter int BGWIDTH      = 2,
   parameter int BAWIDTH      = 2,
   parameter int ADDRWIDTH    = 17,
   parameter int COLWIDTH     = 10,
   parameter int DEVICE_WIDTH = 4,
   parameter int BL           = 8,
   parameter int RDLAT        = 1
) (
   input  logic                                                         clk,
   input  logic                                                         reset,
   input  logic                                                         req_valid,
   output logic                                                         req_ready,
   input  logic                                                         req_write,
   input  logic [BGWIDTH-1:0]                                           req_bg,
   input  logic [BAWIDTH-1:0]                                           req_ba,
   input  logic [ADDRWIDTH-1:0]                                         req_row,
   input  logic [COLWIDTH-1:0]                                          req_col,
   input  logic                                                         wdata_valid,
   output logic                                                         wdata_ready,
   input  logic [DEVICE_WIDTH-1:0]                                      wdata,
   output logic                                                         rdata_valid,
   output logic [DEVICE_WIDTH-1:0]                                      rdata,
   output logic                                                         rdata_last,
   output logic [2**BGWIDTH-1:0][2**BAWIDTH-1:0]                        rd_o_wr,
   output logic [2**BGWIDTH-1:0][2**BAWIDTH-1:0][ADDRWIDTH-1:0]         row,
   output logic [2**BGWIDTH-1:0][2**BAWIDTH-1:0][COLWIDTH-1:0]          column,
   output logic [2**BGWIDTH-1:0][2**BAWIDTH-1:0][DEVICE_WIDTH-1:0]      dqin,
   input  logic [2**BGWIDTH-1:0][2**BAWIDTH-1:0][DEVICE_WIDTH-1:0]      dqout
);

   localparam int LBL = $clog2(BL);
   localparam logic [LBL-1:0] LAST = LBL'(BL - 1);

   typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

   typedef struct packed {
      logic [BGWIDTH-1:0]   bg;
      logic [BAWIDTH-1:0]   ba;
      logic [ADDRWIDTH-1:0] row;
      logic [COLWIDTH-1:0]  col;
   } req_t;

   state_t                  state, state_nx;
   req_t                    req_q, req_nx, beat_req;
   logic [LBL-1:0]          k_q, k_nx, beat_k;
   logic                    beat_en, beat_wr, rd_beat, rd_last;
   logic [DEVICE_WIDTH-1:0] beat_dq;
   logic [COLWIDTH-1:0]     beat_col;
   logic                    ready_en;
   logic [RDLAT:0]          vld_sr, last_sr;

   assign req_ready   = (state == IDLE) && ready_en;
   assign wdata_ready = (state == WRITE);

   // Beat offset wraps inside the BL-aligned block; upper column bits are kept.
   assign beat_col = {beat_req.col[COLWIDTH-1:LBL], beat_req.col[LBL-1:0] + beat_k};
   assign rd_beat  = beat_en && !beat_wr;
   assign rd_last  = rd_beat && (beat_k == LAST);

   always_comb begin
      state_nx = state;
      req_nx   = req_q;
      k_nx     = k_q;
      beat_en  = 1'b0;
      beat_wr  = 1'b0;
      beat_req = req_q;
      beat_k   = k_q;
      beat_dq  = '0;
      case (state)
         IDLE: begin
            if (req_valid && req_ready) begin
               req_nx = '{bg: req_bg, ba: req_ba, row: req_row, col: req_col};
               k_nx   = '0;
               if (req_write) begin
                  state_nx = WRITE;
               end else begin
                  // Read beat 0 is issued straight from the request so it lands in the first busy cycle.
                  beat_en  = 1'b1;
                  beat_req = req_nx;
                  beat_k   = '0;
                  k_nx     = LBL'(1);
                  state_nx = READ;
               end
            end
         end
         WRITE: begin
            if (wdata_valid) begin
               beat_en = 1'b1;
               beat_wr = 1'b1;
               beat_dq = wdata;
               k_nx    = k_q + 1'b1;
               if (k_q == LAST) state_nx = IDLE;
            end
         end
         READ: begin
            beat_en = 1'b1;
            k_nx    = k_q + 1'b1;
            if (k_q == LAST) state_nx = DRAIN;
         end
         DRAIN: begin
            if (rdata_valid && rdata_last) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         req_q    <= '0;
         k_q      <= '0;
         ready_en <= 1'b0;
      end else begin
         state    <= state_nx;
         req_q    <= req_nx;
         k_q      <= k_nx;
         ready_en <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_o_wr <= '0;
         row     <= '0;
         column  <= '0;
         dqin    <= '0;
      end else begin
         rd_o_wr <= '0;
         row     <= '0;
         column  <= '0;
         dqin    <= '0;
         if (beat_en) begin
            rd_o_wr[beat_req.bg][beat_req.ba] <= beat_wr;
            row[beat_req.bg][beat_req.ba]     <= beat_req.row;
            column[beat_req.bg][beat_req.ba]  <= beat_col;
            dqin[beat_req.bg][beat_req.ba]    <= beat_dq;
         end
      end
   end

   // Stage 0 lines up with the registered column; stage RDLAT marks the cycle dqout is valid.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_sr      <= '0;
         last_sr     <= '0;
         rdata_valid <= 1'b0;
         rdata_last  <= 1'b0;
         rdata       <= '0;
      end else begin
         vld_sr[0]  <= rd_beat;
         last_sr[0] <= rd_last;
         for (int i = 1; i <= RDLAT; i++) begin
            vld_sr[i]  <= vld_sr[i-1];
            last_sr[i] <= last_sr[i-1];
         end
         rdata_valid <= vld_sr[RDLAT];
         rdata_last  <= last_sr[RDLAT];
         rdata       <= vld_sr[RDLAT] ? dqout[req_q.bg][req_q.ba] : '0;
      end
   end

endmodule

// File: tb/tb_ddr_burst_sequencer.sv
// Directed bench for ddr_burst_sequencer with a one-bank behavioural chip (RDLAT = 1) on bank [1][1].
module tb_ddr_burst_sequencer;

   localparam int NBG = 4;
   localparam int NBA = 4;

   logic clk, reset;
   logic req_valid, req_ready, req_write;
   logic [1:0] req_bg, req_ba;
   logic [16:0] req_row;
   logic [9:0] req_col;
   logic wdata_valid, wdata_ready;
   logic [3:0] wdata;
   logic rdata_valid, rdata_last;
   logic [3:0] rdata;
   logic [NBG-1:0][NBA-1:0]        rd_o_wr;
   logic [NBG-1:0][NBA-1:0][16:0]  row;
   logic [NBG-1:0][NBA-1:0][9:0]   column;
   logic [NBG-1:0][NBA-1:0][3:0]   dqin;
   logic [NBG-1:0][NBA-1:0][3:0]   dqout;

   int checks = 0;
   int errors = 0;

   logic [3:0] wd   [8];
   logic [9:0] ecol [8];
   logic [3:0] edat [8];
   logic [3:0] mem  [1024];
   logic [3:0] dq_m;

   ddr_burst_sequencer dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row), .req_col(req_col),
      .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
      .rdata_valid(rdata_valid), .rdata(rdata), .rdata_last(rdata_last),
      .rd_o_wr(rd_o_wr), .row(row), .column(column), .dqin(dqin), .dqout(dqout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Chip model for bank [1][1]: writes land at the edge, read data follows the column by one cycle.
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 4'(i) ^ 4'h5;
      end else if (rd_o_wr[1][1]) begin
         mem[column[1][1]] <= dqin[1][1];
      end
      dq_m <= mem[column[1][1]];
   end

   always_comb begin
      for (int g = 0; g < NBG; g++)
         for (int b = 0; b < NBA; b++)
            dqout[g][b] = 4'h6;
      dqout[1][1] = dq_m;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_bank(input string tag, input logic en, input logic wr,
                           input logic [9:0] c, input logic [3:0] d);
      logic [NBG-1:0][NBA-1:0]       e_wr;
      logic [NBG-1:0][NBA-1:0][16:0] e_row;
      logic [NBG-1:0][NBA-1:0][9:0]  e_col;
      logic [NBG-1:0][NBA-1:0][3:0]  e_dq;
      e_wr = '0; e_row = '0; e_col = '0; e_dq = '0;
      if (en) begin
         e_wr[1][1]  = wr;
         e_row[1][1] = 17'd1;
         e_col[1][1] = c;
         e_dq[1][1]  = d;
      end
      chk({tag, ".rd_o_wr"}, 512'(rd_o_wr), 512'(e_wr));
      chk({tag, ".row"},     512'(row),     512'(e_row));
      chk({tag, ".column"},  512'(column),  512'(e_col));
      chk({tag, ".dqin"},    512'(dqin),    512'(e_dq));
   endtask

   task automatic issue(input logic wr, input logic [9:0] c);
      req_valid = 1'b1; req_write = wr; req_bg = 2'd1; req_ba = 2'd1; req_row = 17'd1; req_col = c;
      tick();
      req_valid = 1'b0;
   endtask

   // stall_at < 0: continuous beats; otherwise two idle cycles after beat stall_at.
   task automatic do_write(input string tag, input int stall_at);
      int nslots, b;
      nslots = (stall_at < 0) ? 8 : 10;
      issue(1'b1, 10'd0);
      chk({tag, ".busy_req_ready"}, 512'(req_ready), 512'(1'b0));
      chk({tag, ".wdata_ready"}, 512'(wdata_ready), 512'(1'b1));
      for (int s = 0; s < nslots; s++) begin
         if (stall_at < 0 || s <= stall_at) b = s;
         else if (s <= stall_at + 2) b = -1;
         else b = s - 2;
         wdata_valid = (b >= 0);
         wdata = (b >= 0) ? wd[b] : 4'h0;
         tick();
         chk_bank($sformatf("%s.slot%0d", tag, s), b >= 0, 1'b1, (b >= 0) ? 10'(b) : 10'd0,
                  (b >= 0) ? wd[b] : 4'h0);
         chk($sformatf("%s.req_ready%0d", tag, s), 512'(req_ready), 512'(s == nslots - 1));
      end
      wdata_valid = 1'b0;
      tick();
      chk_bank({tag, ".after"}, 1'b0, 1'b0, 10'd0, 4'h0);
   endtask

   task automatic do_read(input string tag, input logic [9:0] c);
      issue(1'b0, c);
      wdata_valid = 1'b1;
      wdata = 4'hF;
      for (int n = 1; n <= 12; n++) begin
         chk_bank($sformatf("%s.C%0d", tag, n), n <= 8, 1'b0, (n <= 8) ? ecol[n-1] : 10'd0, 4'h0);
         chk($sformatf("%s.rdata_valid%0d", tag, n), 512'(rdata_valid), 512'(n >= 3 && n <= 10));
         chk($sformatf("%s.rdata%0d", tag, n), 512'(rdata), 512'((n >= 3 && n <= 10) ? edat[n-3] : 4'h0));
         chk($sformatf("%s.rdata_last%0d", tag, n), 512'(rdata_last), 512'(n == 10));
         chk($sformatf("%s.req_ready%0d", tag, n), 512'(req_ready), 512'(n >= 11));
         tick();
      end
      wdata_valid = 1'b0;
   endtask

   initial begin
      int vcount;
      wd = '{4'hA, 4'hB, 4'h8, 4'h9, 4'hE, 4'hF, 4'hC, 4'hD};
      reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_bg = '0; req_ba = '0;
      req_row = '0; req_col = '0; wdata_valid = 1'b0; wdata = '0;

      // Test 1: asynchronous reset mid-cycle
      #2 reset = 1'b1;
      #1;
      chk_bank("t1.reset", 1'b0, 1'b0, 10'd0, 4'h0);
      chk("t1.req_ready", 512'(req_ready), 512'(1'b0));
      chk("t1.wdata_ready", 512'(wdata_ready), 512'(1'b0));
      chk("t1.rdata_valid", 512'(rdata_valid), 512'(1'b0));
      chk("t1.rdata", 512'(rdata), 512'(4'h0));
      chk("t1.rdata_last", 512'(rdata_last), 512'(1'b0));
      tick();
      tick();
      reset = 1'b0;
      chk("t1.ready_at_deassert", 512'(req_ready), 512'(1'b0));
      tick();
      chk("t1.ready_after", 512'(req_ready), 512'(1'b1));

      // wdata while idle is ignored
      wdata_valid = 1'b1; wdata = 4'hF;
      chk("t1.idle_wdata_ready", 512'(wdata_ready), 512'(1'b0));
      tick();
      chk_bank("t1.idle_wdata", 1'b0, 1'b0, 10'd0, 4'h0);
      wdata_valid = 1'b0;

      // Test 2: continuous write burst
      do_write("t2", -1);

      // Test 3: write with two stall cycles after beat 3
      do_write("t3", 3);

      // Test 4: read col 5, wraps within the aligned block
      ecol = '{10'd5, 10'd6, 10'd7, 10'd0, 10'd1, 10'd2, 10'd3, 10'd4};
      edat = '{4'hF, 4'hC, 4'hD, 4'hA, 4'hB, 4'h8, 4'h9, 4'hE};
      do_read("t4", 10'd5);

      // Test 5: read col 0x3FD keeps upper column bits
      ecol = '{10'h3FD, 10'h3FE, 10'h3FF, 10'h3F8, 10'h3F9, 10'h3FA, 10'h3FB, 10'h3FC};
      edat = '{4'h8, 4'hB, 4'hA, 4'hD, 4'hC, 4'hF, 4'hE, 4'h9};
      do_read("t5", 10'h3FD);

      // Test 6: reset in C4 of a read, then a normal write
      issue(1'b0, 10'd0);
      tick();
      tick();
      tick();
      chk("t6.rdata_valid_C4", 512'(rdata_valid), 512'(1'b1));
      reset = 1'b1;
      #1;
      chk_bank("t6.reset", 1'b0, 1'b0, 10'd0, 4'h0);
      chk("t6.rdata_valid", 512'(rdata_valid), 512'(1'b0));
      chk("t6.req_ready", 512'(req_ready), 512'(1'b0));
      tick();
      reset = 1'b0;
      vcount = 0;
      for (int n = 0; n < 12; n++) begin
         tick();
         if (rdata_valid) vcount++;
      end
      chk("t6.no_rdata_after_reset", 512'(vcount), 512'(0));
      chk("t6.req_ready_after", 512'(req_ready), 512'(1'b1));
      do_write("t6w", -1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
